// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads on the imem req/ack bus
// and feeds IF/ID through a registered output slot backed by a one-entry skid buffer.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o
);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  fetch_t            skid;
  logic              drop;

  logic              slot_free;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] addr_nxt;

  assign slot_free = !if_valid_o || !stall_i;
  assign tgt       = {branch_target_i[ADDR_W-1:2], 2'b00};
  assign addr_nxt  = imem_addr_o + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      if_valid_o  <= 1'b0;
      if_pc_o     <= '0;
      if_inst_o   <= '0;
      skid        <= '0;
      drop        <= 1'b0;
    end else begin
      if (if_valid_o && !stall_i)
        if_valid_o <= 1'b0;

      if (branch_flag_i) begin
        if_valid_o <= 1'b0;
        pc         <= tgt;
        skid       <= '0;
        // An unacked read can't be cancelled on this bus: swallow its ack later.
        if (state == REQ && !imem_ack_i) begin
          drop <= 1'b1;
        end else begin
          drop        <= 1'b0;
          state       <= REQ;
          imem_req_o  <= 1'b1;
          imem_addr_o <= tgt;
        end
      end else begin
        unique case (state)
          IDLE: begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end
          REQ: begin
            if (imem_ack_i) begin
              if (drop) begin
                drop        <= 1'b0;
                imem_addr_o <= pc;
              end else if (slot_free) begin
                if_valid_o  <= 1'b1;
                if_pc_o     <= imem_addr_o;
                if_inst_o   <= imem_rdata_i;
                pc          <= addr_nxt;
                imem_addr_o <= addr_nxt;
              end else begin
                skid       <= '{pc: imem_addr_o, inst: imem_rdata_i};
                pc         <= addr_nxt;
                imem_req_o <= 1'b0;
                state      <= FULL;
              end
            end
          end
          FULL: begin
            if (!stall_i) begin
              if_valid_o  <= 1'b1;
              if_pc_o     <= skid.pc;
              if_inst_o   <= skid.inst;
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, stall/skid, in-flight redirect,
// branch-on-ack, PC wrap and reset during an outstanding read.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int nvec = 0;
  int nerr = 0;

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // One cycle of stimulus; memory returns mem(addr) for whatever address is on the bus.
  task automatic drive(input logic ack, input logic stl, input logic br, input logic [31:0] t);
    imem_ack_i      = ack;
    stall_i         = stl;
    branch_flag_i   = br;
    branch_target_i = t;
    imem_rdata_i    = ack ? mem(imem_addr_o) : 32'hBAD0_BAD0;
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p);
    chk({tag, ".valid"}, 32'(if_valid_o), 32'(v));
    if (v) begin
      chk({tag, ".pc"},   if_pc_o,   p);
      chk({tag, ".inst"}, if_inst_o, mem(p));
    end
  endtask

  task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, 32'(imem_req_o), 32'(r));
    if (r) chk({tag, ".addr"}, imem_addr_o, a);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(imem_req_o), 32'h0);
    chk("rst.addr",  imem_addr_o,     32'h0);
    chk("rst.valid", 32'(if_valid_o), 32'h0);
    chk("rst.pc",    if_pc_o,         32'h0);
    chk("rst.inst",  if_inst_o,       32'h0);

    rst = 1'b0;
    @(posedge clk); #1;
    chk_bus("start", 1'b1, 32'h0);
    chk("start.valid", 32'(if_valid_o), 32'h0);

    // Back-to-back stream
    drive(1, 0, 0, 0); chk_out("s0", 1, 32'h0); chk_bus("s0", 1, 32'h4);
    drive(1, 0, 0, 0); chk_out("s1", 1, 32'h4); chk_bus("s1", 1, 32'h8);
    drive(1, 0, 0, 0); chk_out("s2", 1, 32'h8); chk_bus("s2", 1, 32'hC);

    // Stall while 8 presented: C goes to the skid buffer
    drive(1, 1, 0, 0); chk_out("stl0", 1, 32'h8); chk_bus("stl0", 0, 32'h0);
    drive(0, 1, 0, 0); chk_out("stl1", 1, 32'h8); chk_bus("stl1", 0, 32'h0);
    drive(0, 0, 0, 0); chk_out("stl2", 1, 32'hC); chk_bus("stl2", 1, 32'h10);

    drive(1, 0, 0, 0); chk_out("s3", 1, 32'h10);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0); chk_out("s6", 1, 32'h1C); chk_bus("s6", 1, 32'h20);

    // Redirect while the read of 0x20 is outstanding
    drive(0, 0, 1, 32'h103); chk_out("rd0", 0, 0); chk_bus("rd0", 1, 32'h20);
    drive(0, 0, 0, 0);       chk_out("rd1", 0, 0); chk_bus("rd1", 1, 32'h20);
    drive(0, 0, 0, 0);       chk_out("rd2", 0, 0);
    drive(1, 0, 0, 0);       chk_out("rd3", 0, 0); chk_bus("rd3", 1, 32'h100);
    drive(1, 0, 0, 0);       chk_out("rd4", 1, 32'h100); chk_bus("rd4", 1, 32'h104);

    // Branch coinciding with ack and stall
    drive(1, 1, 1, 32'h200); chk_out("ba0", 0, 0); chk_bus("ba0", 1, 32'h200);
    drive(1, 0, 0, 0);       chk_out("ba1", 1, 32'h200); chk_bus("ba1", 1, 32'h204);

    // Wrap; target low bits must be masked
    drive(1, 0, 1, 32'hFFFF_FFFF); chk_out("w0", 0, 0); chk_bus("w0", 1, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0); chk_out("w1", 1, 32'hFFFF_FFFC); chk_bus("w1", 1, 32'h0);
    drive(1, 0, 0, 0); chk_out("w2", 1, 32'h0);         chk_bus("w2", 1, 32'h4);

    // Reset mid-read, late ack during and right after reset
    imem_ack_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mr.req",   32'(imem_req_o), 32'h0);
    chk("mr.addr",  imem_addr_o,     32'h0);
    chk("mr.valid", 32'(if_valid_o), 32'h0);
    chk("mr.pc",    if_pc_o,         32'h0);
    chk("mr.inst",  if_inst_o,       32'h0);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr.idle.valid", 32'(if_valid_o), 32'h0);
    chk_bus("mr.restart", 1'b1, 32'h0);
    drive(1, 0, 0, 0); chk_out("mr.s0", 1, 32'h0); chk_bus("mr.s0", 1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage: the producer for the IF/ID pipeline register. Holds the program counter and issues word reads on the instruction-memory request/acknowledge bus. Presents each fetched instruction with its PC on a valid/stall output toward IF/ID. Handles redirects from the branch unit, including redirects that arrive while a memory read is in flight.

## Interface
- ADDR_W, 32, PC / instruction-address width (InstAddrBus)
- INST_W, 32, instruction width (InstBus)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  IF/ID cannot accept; output is consumed in any cycle with if_valid_o=1 and stall_i=0
- branch_flag_i  in  1  redirect request, single-cycle pulse
- branch_target_i  in  ADDR_W  redirect address; bits [1:0] are ignored (forced 0)
- imem_req_o  out  1  read request
- imem_addr_o  out  ADDR_W  read address, word aligned
- imem_ack_i  in  1  read complete; may assert in the same cycle req first rises
- imem_rdata_i  in  INST_W  read data, valid when imem_ack_i=1
- if_valid_o  out  1  if_pc_o/if_inst_o hold a valid instruction
- if_pc_o  out  ADDR_W  PC of presented instruction
- if_inst_o  out  INST_W  presented instruction

## Operation
- Registers:
  - pc (next fetch address)
  - output slot {if_valid_o, if_pc_o, if_inst_o}
  - one-entry skid buffer {buf_pc, buf_inst}
  - drop flag
  - redirect target
- Reset values: pc=RESET_PC, state=IDLE, imem_req_o=0, imem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0, buffer empty, drop=0.
- Slot free this cycle: if_valid_o=0 or stall_i=0.
- IDLE: entered only from reset. Go to REQ next cycle with imem_addr_o=pc.
- REQ: imem_req_o=1; imem_addr_o stays stable until ack.
  - Ack, drop=0, no branch, slot free: load output slot with {addr, rdata}, valid=1. pc and imem_addr_o advance by 4. Stay in REQ, so back-to-back requests are issued.
  - Ack, drop=0, no branch, slot not free: write {addr, rdata} to buffer, deassert req, go to FULL. pc advances by 4.
  - Ack with drop=1: discard data, clear drop, set imem_addr_o=pc (the stored target), stay in REQ.
- FULL: imem_req_o=0. When stall_i=0, move buffer to the output slot, go to REQ with imem_addr_o=pc.
- Output slot with no new load: if consumed, valid clears; otherwise it holds unchanged.
- Branch (branch_flag_i=1) in any state, highest priority over stall and ack:
  - Output valid clears next cycle.
  - Buffer is emptied.
  - pc = target & ~3.
  - Request in flight without ack this cycle: set drop, keep imem_addr_o unchanged, then discard that ack and fetch the target.
  - Otherwise (ack this cycle, IDLE, or FULL): next cycle is REQ with imem_addr_o=target. Ack data in that cycle is discarded.
  - A second branch while drop=1 overwrites pc. The latest target wins, and only one pending ack is dropped.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 32'hFFFF_FFFC wraps to 0 with no error.
- Reset mid-read: state returns to IDLE and req drops next cycle. The memory must tolerate the abandoned request; a late ack in IDLE is ignored.

## Timing
- Reset released at cycle 0: cycle 1 has req=1, addr=RESET_PC.
- Ack in cycle n gives if_valid_o=1 in cycle n+1; latency from ack to output is 1 cycle.
- With ack in every cycle and stall_i=0, throughput is 1 instruction/cycle.
- Branch at cycle n gives if_valid_o=0 at n+1.
  - No request in flight: req with target at n+1.
  - Request in flight: target is requested the cycle after the dropped ack.
- FULL exit: stall_i falls at cycle n; buffered instruction is valid at n+1 and the next req is issued at n+1.
- Outputs change only on posedge clk; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, RESET_PC=0, ack every cycle, stall_i=0: addresses 0,4,8,C; if_pc_o 0,4,8,C on consecutive cycles starting one cycle after the first ack.
- Stall: raise stall_i while pc=8 is presented, ack for C arrives → C buffered, req=0, output holds 8. Drop stall → output C next cycle, req for 0x10 issued the same cycle.
- Redirect in flight: req addr=0x20 with ack delayed 3 cycles, branch to 0x103 in the first wait cycle → ack data for 0x20 never appears on the output. Next req addr=0x100; if_pc_o=0x100 after its ack.
- Branch coinciding with ack and stall_i=1: ack data dropped, if_valid_o=0 next cycle, req for target next cycle.
- Wrap: branch to 0xFFFF_FFFC, acks → if_pc_o 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted mid-read with an outstanding req → all outputs at reset values the next cycle, a late ack has no effect, and fetch restarts at RESET_PC.
